// File: rtl/ring_delay_ctrl.sv
// ring_delay_ctrl: splits a ring-oscillator period into per-stage delays.
// Define RING_DELAY_ROTATE_EN to rotate the long-delay stages around the ring.
module ring_delay_ctrl #(
  parameter int N_STAGES = 16,
  parameter int PERIOD_W = 32,
  parameter int DELAY_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [PERIOD_W-1:0]         period_fs,
  input  logic                        period_valid,
  output logic                        period_ready,
  output logic [N_STAGES*DELAY_W-1:0] inv_delay_fs,
  output logic                        delay_valid
);

  localparam int D  = 2 * N_STAGES;
  localparam int RW = $clog2(D) + 1;
  localparam int CW = $clog2(PERIOD_W) + 1;
  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int XW = (PERIOD_W + 1 > DELAY_W) ? PERIOD_W + 1 : DELAY_W;
  localparam logic [RW-1:0] D_W  = RW'(D);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DIST
  } state_t;

  state_t state, state_next;

  logic [PERIOD_W-1:0] dvd;
  logic [PERIOD_W-1:0] quo;
  logic [RW-1:0]       rem;
  logic [CW-1:0]       cnt;
  logic                res;
  logic [SW-1:0]       start;
  logic                accept;

  logic [RW-1:0] trial;
  logic [RW-1:0] step_rem;
  logic          step_bit;

  logic [RW-1:0] s;
  int            nl;
  logic [XW-1:0] q_ext;
  logic [XW-1:0] q1_ext;
  logic [XW-1:0] dmax;
  logic [DELAY_W-1:0] short_d;
  logic [DELAY_W-1:0] long_d;
  logic [N_STAGES*DELAY_W-1:0] dist_delays;
  logic [SW-1:0] start_next;

  assign period_ready = (state == IDLE) & en & ~rst;
  assign accept       = period_valid & period_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DIV;
      DIV:     if (cnt == LAST) state_next = DIST;
      DIST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Restoring division by D, one quotient bit per cycle, MSB first.
  always_comb begin
    trial    = {rem[RW-2:0], dvd[PERIOD_W-1]};
    step_bit = (trial >= D_W);
    step_rem = step_bit ? (trial - D_W) : trial;
  end

  always_comb begin
    s      = rem + RW'(res);
    nl     = int'(s >> 1);
    q_ext  = '0;
    q_ext[PERIOD_W-1:0] = quo;
    q1_ext = q_ext + XW'(1);
    dmax   = '0;
    dmax[DELAY_W-1:0] = '1;
    short_d = (q_ext > dmax) ? dmax[DELAY_W-1:0] : q_ext[DELAY_W-1:0];
    long_d  = (q1_ext > dmax) ? dmax[DELAY_W-1:0] : q1_ext[DELAY_W-1:0];
    dist_delays = '0;
    for (int j = 0; j < N_STAGES; j++) begin
      dist_delays[j*DELAY_W +: DELAY_W] =
        (((j + N_STAGES - int'(start)) % N_STAGES) < nl) ? long_d : short_d;
    end
  end

`ifdef RING_DELAY_ROTATE_EN
  always_comb begin
    start_next = SW'((int'(start) + nl) % N_STAGES);
  end
`else
  assign start_next = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd          <= '0;
      quo          <= '0;
      rem          <= '0;
      cnt          <= '0;
      res          <= 1'b0;
      start        <= '0;
      inv_delay_fs <= '0;
      delay_valid  <= 1'b0;
    end else begin
      delay_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dvd <= period_fs;
            quo <= '0;
            rem <= '0;
            cnt <= '0;
          end
        end
        DIV: begin
          dvd <= dvd << 1;
          rem <= step_rem;
          quo <= {quo[PERIOD_W-2:0], step_bit};
          cnt <= cnt + CW'(1);
        end
        DIST: begin
          inv_delay_fs <= dist_delays;
          res          <= s[0];
          start        <= start_next;
          delay_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_delay_ctrl.sv
// Scoreboard bench for ring_delay_ctrl (N_STAGES=16, PERIOD_W=32, DELAY_W=32).
// Honours RING_DELAY_ROTATE_EN in its reference model.
module tb_ring_delay_ctrl;

  localparam int N  = 16;
  localparam int PW = 32;
  localparam int DW = 32;
  localparam int LAT = PW + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [PW-1:0]   period_fs;
  logic            period_valid;
  logic            period_ready;
  logic [N*DW-1:0] inv_delay_fs;
  logic            delay_valid;

  int n_run  = 0;
  int n_fail = 0;

  logic [N*DW-1:0] sb[$];
  logic            res_m;
  int              start_m;

  ring_delay_ctrl #(
    .N_STAGES(N),
    .PERIOD_W(PW),
    .DELAY_W (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .period_fs   (period_fs),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .inv_delay_fs(inv_delay_fs),
    .delay_valid (delay_valid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    res_m   = 1'b0;
    start_m = 0;
    sb.delete();
  endtask

  task automatic model_push(input logic [PW-1:0] p);
    logic [N*DW-1:0] v;
    logic [PW-1:0]   q;
    int              r, s, nl;
    q  = p / 32;
    r  = int'(p % 32);
    s  = r + int'(res_m);
    nl = s / 2;
    res_m = s[0];
    for (int j = 0; j < N; j++)
      v[j*DW +: DW] = (((j - start_m + N) % N) < nl) ? q + 1 : q;
`ifdef RING_DELAY_ROTATE_EN
    start_m = (start_m + nl) % N;
`endif
    sb.push_back(v);
  endtask

  task automatic issue(input logic [PW-1:0] p, output bit acc);
    @(negedge clk);
    period_fs    = p;
    period_valid = 1'b1;
    acc = period_ready;
    @(posedge clk);
    #1 period_valid = 1'b0;
    if (acc) model_push(p);
  endtask

  // lat = number of edges after the accept edge at which delay_valid is sampled high
  task automatic collect(input int budget, output bit got, output int lat,
                         output logic [N*DW-1:0] d);
    got = 1'b0;
    lat = 0;
    d   = '0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (delay_valid) begin
        got = 1'b1;
        lat = k + 1;
        d   = inv_delay_fs;
      end
    end
  endtask

  function automatic int count_val(input logic [N*DW-1:0] d, input logic [DW-1:0] v);
    int c = 0;
    for (int j = 0; j < N; j++) if (d[j*DW +: DW] == v) c++;
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    n_run++;
    if (inv_delay_fs !== '0 || delay_valid !== 1'b0 || period_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: delays=%0h valid=%b ready=%b, required 0/0/0",
               inv_delay_fs, delay_valid, period_ready);
    end
    rst = 1'b0;
    model_reset();
    #1;
    n_run++;
    if (period_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b, required 1", period_ready);
    end
  endtask

  task automatic test_even();
    bit acc, got;
    int lat;
    logic [N*DW-1:0] d, e;
    issue(32'd400000, acc);
    collect(80, got, lat, d);
    n_run++;
    if (!acc || !got || lat != LAT) begin
      n_fail++;
      $display("FAIL even_latency: acc=%b got=%b lat=%0d, required 1/1/%0d", acc, got, lat, LAT);
    end
    e = sb.pop_front();
    n_run++;
    if (d !== e || count_val(d, 32'd12500) != N) begin
      n_fail++;
      $display("FAIL even_data: n12500=%0d, required %0d", count_val(d, 32'd12500), N);
    end
    @(negedge clk);
    n_run++;
    if (delay_valid !== 1'b0 || inv_delay_fs !== d) begin
      n_fail++;
      $display("FAIL even_pulse: valid=%b held=%b, required 0/1", delay_valid, inv_delay_fs === d);
    end
  endtask

  task automatic test_residual();
    bit acc, got;
    int lat;
    logic [N*DW-1:0] d, e;
    int longs [3] = '{5, 5, 6};
    logic [PW-1:0] ps [3] = '{32'd400010, 32'd400011, 32'd400011};
    for (int t = 0; t < 3; t++) begin
      issue(ps[t], acc);
      collect(80, got, lat, d);
      e = sb.pop_front();
      n_run++;
      if (!got || d !== e || count_val(d, 32'd12501) != longs[t]) begin
        n_fail++;
        $display("FAIL residual_%0d: got=%b n12501=%0d, required 1/%0d",
                 t, got, count_val(d, 32'd12501), longs[t]);
      end
`ifndef RING_DELAY_ROTATE_EN
      if (t == 0) begin
        n_run++;
        if (d[4*DW +: DW] !== 32'd12501 || d[5*DW +: DW] !== 32'd12500) begin
          n_fail++;
          $display("FAIL residual_placement: s4=%0d s5=%0d, required 12501/12500",
                   d[4*DW +: DW], d[5*DW +: DW]);
        end
      end
`endif
    end
  endtask

  task automatic test_small();
    bit acc, got;
    int lat;
    logic [N*DW-1:0] d, e;
    // leaves res=1 in the model and the DUT
    issue(32'd400011, acc);
    collect(80, got, lat, d);
    e = sb.pop_front();
    issue(32'd31, acc);
    collect(80, got, lat, d);
    e = sb.pop_front();
    n_run++;
    if (!got || d !== e || count_val(d, 32'd1) != N) begin
      n_fail++;
      $display("FAIL small_carry: n1=%0d, required %0d", count_val(d, 32'd1), N);
    end
    do_reset();
    issue(32'd31, acc);
    collect(80, got, lat, d);
    e = sb.pop_front();
    n_run++;
    if (!got || d !== e || count_val(d, 32'd1) != 15 || count_val(d, 32'd0) != 1) begin
      n_fail++;
      $display("FAIL small_fresh: n1=%0d n0=%0d, required 15/1",
               count_val(d, 32'd1), count_val(d, 32'd0));
    end
  endtask

  task automatic test_busy();
    bit acc, got, busy_ok;
    int lat;
    logic [N*DW-1:0] d, e;
    issue(32'd400000, acc);
    busy_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      period_fs    = 32'd12345;
      period_valid = 1'b1;
      if (period_ready !== 1'b0) busy_ok = 1'b0;
    end
    period_valid = 1'b0;
    n_run++;
    if (!busy_ok) begin
      n_fail++;
      $display("FAIL busy_ready: ready seen=1, required 0");
    end
    collect(40, got, lat, d);
    e = sb.pop_front();
    n_run++;
    if (!got || d !== e) begin
      n_fail++;
      $display("FAIL busy_data: got=%b s0=%0d, required 1/%0d", got, d[DW-1:0], e[DW-1:0]);
    end
    collect(40, got, lat, d);
    n_run++;
    if (got) begin
      n_fail++;
      $display("FAIL busy_extra: extra pulse=%b, required 0", got);
    end
  endtask

  task automatic test_enable();
    bit acc, got;
    int lat;
    logic [N*DW-1:0] d, e, held;
    held = inv_delay_fs;
    en = 1'b0;
    issue(32'd777777, acc);
    collect(40, got, lat, d);
    n_run++;
    if (acc || got || inv_delay_fs !== held) begin
      n_fail++;
      $display("FAIL en_low: acc=%b pulse=%b, required 0/0", acc, got);
    end
    en = 1'b1;
    issue(32'd400011, acc);
    repeat (3) @(negedge clk);
    en = 1'b0;
    collect(80, got, lat, d);
    e = sb.pop_front();
    n_run++;
    if (!got || lat != LAT - 3 || d !== e) begin
      n_fail++;
      $display("FAIL en_drop: got=%b lat=%0d, required 1/%0d", got, lat, LAT - 3);
    end
    en = 1'b1;
  endtask

  task automatic test_rst_mid();
    bit acc, got;
    int lat;
    logic [N*DW-1:0] d;
    issue(32'd400000, acc);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_run++;
    if (inv_delay_fs !== '0 || delay_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: nonzero=%b valid=%b, required 0/0",
               inv_delay_fs !== '0, delay_valid);
    end
    rst = 1'b0;
    model_reset();
    #1;
    n_run++;
    if (period_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_ready: ready=%b, required 1", period_ready);
    end
    collect(45, got, lat, d);
    n_run++;
    if (got || inv_delay_fs !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_abandon: pulse=%b nonzero=%b, required 0/0",
               got, inv_delay_fs !== '0);
    end
  endtask

  task automatic test_back_to_back();
    bit acc, got;
    int lat;
    logic [N*DW-1:0] d, e;
    logic [PW-1:0] p;
    issue(32'd400010, acc);
    for (int t = 0; t < 6; t++) begin
      collect(80, got, lat, d);
      e = sb.pop_front();
      n_run++;
      if (!got || d !== e) begin
        n_fail++;
        $display("FAIL b2b_%0d: got=%b s0=%0d s15=%0d, required 1/%0d/%0d",
                 t, got, d[DW-1:0], d[15*DW +: DW], e[DW-1:0], e[15*DW +: DW]);
      end
      if (t < 5) begin
        p = (t == 2) ? 32'hFFFF_FFFF : $urandom;
        period_fs    = p;
        period_valid = 1'b1;
        acc = period_ready;
        @(posedge clk);
        #1 period_valid = 1'b0;
        if (acc) model_push(p);
        n_run++;
        if (!acc) begin
          n_fail++;
          $display("FAIL b2b_ready_%0d: ready=%b, required 1", t, acc);
        end
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    period_fs    = '0;
    period_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_even();
    test_residual();
    test_small();
    test_busy();
    test_enable();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
